// File: rtl/idct_blok_gonderici_if.sv
// Write/read channel bundle for idct_blok_gonderici.
//   Write side : yaz_veri_i, yaz_gecerli_i (into block), yaz_hazir_o (out of block)
//   Read side  : idct_veri_o, idct_row_o, idct_col_o, idct_gecerli_o,
//                idct_blok_son_o, gonder_bitti_o (out of block), idct_hazir_i (into block)
// slave  = the block's own view, master = the view of whoever drives the block.
interface idct_blok_gonderici_if #(
  parameter int PIXEL_BIT = 8,
  parameter int IN_BIT    = 11,
  parameter int BLOCK_BIT = 3
);
  logic [IN_BIT-1:0]    yaz_veri_i;
  logic                 yaz_gecerli_i;
  logic                 yaz_hazir_o;
  logic [PIXEL_BIT-1:0] idct_veri_o;
  logic [BLOCK_BIT-1:0] idct_row_o;
  logic [BLOCK_BIT-1:0] idct_col_o;
  logic                 idct_gecerli_o;
  logic                 idct_blok_son_o;
  logic                 idct_hazir_i;
  logic                 gonder_bitti_o;

  modport slave (
    input  yaz_veri_i, yaz_gecerli_i, idct_hazir_i,
    output yaz_hazir_o, idct_veri_o, idct_row_o, idct_col_o,
           idct_gecerli_o, idct_blok_son_o, gonder_bitti_o
  );

  modport master (
    output yaz_veri_i, yaz_gecerli_i, idct_hazir_i,
    input  yaz_hazir_o, idct_veri_o, idct_row_o, idct_col_o,
           idct_gecerli_o, idct_blok_son_o, gonder_bitti_o
  );
endinterface

// File: rtl/idct_blok_gonderici.sv
// idct_blok_gonderici: transmit end of the IDCT-to-task-unit pixel stream.
// Collects one 8x8 block of IDCT results (raster order) into a two-bank
// ping-pong buffer and streams each completed block out with row/col tags,
// valid/ready handshake and an end-of-block flag. Filling one bank overlaps
// with streaming the other. After IMG_BLOCKS blocks have been sent the block
// stops accepting writes and raises a sticky done flag until reset.
//
// Ports:
//   clk_i   - clock
//   rstn_i  - asynchronous active-low reset
//   bus     - idct_blok_gonderici_if.slave (write channel + read channel)
//
// Build option:
//   IDCT_DOYURMA_EN - when defined, signed input samples are clamped to
//                     [0, 2^PIXEL_BIT-1]; otherwise the low PIXEL_BIT bits
//                     are taken as-is.
module idct_blok_gonderici #(
  parameter int PIXEL_BIT      = 8,
  parameter int IN_BIT         = 11,
  parameter int BLOCK_SIZE     = 8,
  parameter int BLOCK_BIT      = 3,
  parameter int IMG_BLOCKS     = 16,
  parameter int IMG_BLOCKS_BIT = 5
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  idct_blok_gonderici_if.slave   bus
);

  localparam int AREA    = BLOCK_SIZE * BLOCK_SIZE;
  localparam int IDX_BIT = 2 * BLOCK_BIT;
  localparam logic [IDX_BIT-1:0]        LAST_IDX  = IDX_BIT'(AREA - 1);
  localparam logic [IMG_BLOCKS_BIT-1:0] LAST_BLOK = IMG_BLOCKS_BIT'(IMG_BLOCKS - 1);

  logic [PIXEL_BIT-1:0]      mem [2][AREA];
  logic [1:0]                bank_dolu;
  logic                      wr_bank;
  logic [IDX_BIT-1:0]        wr_idx;
  logic                      rd_bank;
  logic [IDX_BIT-1:0]        rd_idx;
  logic [IMG_BLOCKS_BIT-1:0] blok_sayac;
  logic                      bitti_r;

  logic                      wr_fire;
  logic                      rd_fire;
  logic                      rd_gecerli;
  logic [PIXEL_BIT-1:0]      conv;

  // Sample conversion to pixel width.
`ifdef IDCT_DOYURMA_EN
  always_comb begin
    conv = bus.yaz_veri_i[PIXEL_BIT-1:0];
    if (bus.yaz_veri_i[IN_BIT-1]) begin
      conv = '0;
    end else if (|bus.yaz_veri_i[IN_BIT-2:PIXEL_BIT]) begin
      conv = '1;
    end
  end
`else
  logic unused_ust;
  assign conv       = bus.yaz_veri_i[PIXEL_BIT-1:0];
  assign unused_ust = ^bus.yaz_veri_i[IN_BIT-1:PIXEL_BIT];
`endif

  // Write side is ready only while the bank being filled is empty and the
  // image is not finished.
  assign bus.yaz_hazir_o = !bank_dolu[wr_bank] && !bitti_r;
  assign wr_fire         = bus.yaz_gecerli_i && bus.yaz_hazir_o;

  // Read side presents the head of the full bank directly from storage.
  assign rd_gecerli          = bank_dolu[rd_bank];
  assign rd_fire             = rd_gecerli && bus.idct_hazir_i;
  assign bus.idct_gecerli_o  = rd_gecerli;
  assign bus.idct_veri_o     = rd_gecerli ? mem[rd_bank][rd_idx] : '0;
  assign bus.idct_row_o      = rd_idx[IDX_BIT-1:BLOCK_BIT];
  assign bus.idct_col_o      = rd_idx[BLOCK_BIT-1:0];
  assign bus.idct_blok_son_o = rd_gecerli && (rd_idx == LAST_IDX);
  assign bus.gonder_bitti_o  = bitti_r;

  // Pixel storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem[wr_bank][wr_idx] <= conv;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bank_dolu  <= '0;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      blok_sayac <= '0;
      bitti_r    <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_idx == LAST_IDX) begin
          bank_dolu[wr_bank] <= 1'b1;
          wr_bank            <= !wr_bank;
          wr_idx             <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      // Set and clear always target different banks (writes only to empty
      // banks, reads only from full ones), so both may land on one edge.
      if (rd_fire) begin
        if (rd_idx == LAST_IDX) begin
          bank_dolu[rd_bank] <= 1'b0;
          rd_bank            <= !rd_bank;
          rd_idx             <= '0;
          blok_sayac         <= blok_sayac + 1'b1;
          if (blok_sayac == LAST_BLOK) begin
            bitti_r <= 1'b1;
          end
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_idct_blok_gonderici.sv
module tb_idct_blok_gonderici;

  localparam int IMG_BLOCKS = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  idct_blok_gonderici_if #(.PIXEL_BIT(8), .IN_BIT(11), .BLOCK_BIT(3)) bus ();

  idct_blok_gonderici #(
    .PIXEL_BIT(8), .IN_BIT(11), .BLOCK_SIZE(8), .BLOCK_BIT(3),
    .IMG_BLOCKS(IMG_BLOCKS), .IMG_BLOCKS_BIT(5)
  ) u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: pixels of completed blocks waiting to go out, the
  // partially collected block, and a count of pixels/blocks sent.
  logic [7:0]  exp_q[$];
  logic [7:0]  part_q[$];
  int unsigned sent_px;
  int unsigned blocks_sent;
  bit          done;

  logic        in_g;
  logic [10:0] in_v;
  logic        in_h;

  function automatic logic [7:0] conv_model(input logic [10:0] v);
    int x;
    x = int'($signed(v));
`ifdef IDCT_DOYURMA_EN
    if (x < 0) return 8'd0;
    if (x > 255) return 8'd255;
    return 8'(x);
`else
    return 8'(x & 255);
`endif
  endfunction

  function automatic bit model_wr_ready();
    return (((exp_q.size() + 63) / 64) < 2) && !done;
  endfunction

  // {yaz_hazir, gecerli, blok_son, bitti, row[2:0], col[2:0], veri[7:0]}
  function automatic logic [17:0] model_vec();
    bit          v;
    int unsigned idx;
    logic [7:0]  px;
    v   = exp_q.size() > 0;
    idx = sent_px % 64;
    px  = v ? exp_q[0] : 8'd0;
    return {model_wr_ready(), v, (v && idx == 63), done, 3'(idx / 8), 3'(idx % 8), px};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.yaz_hazir_o, bus.idct_gecerli_o, bus.idct_blok_son_o, bus.gonder_bitti_o,
            bus.idct_row_o, bus.idct_col_o, bus.idct_veri_o};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    part_q.delete();
    sent_px     = 0;
    blocks_sent = 0;
    done        = 0;
  endtask

  task automatic model_edge();
    bit wr, rd;
    wr = in_g && model_wr_ready();
    rd = (exp_q.size() > 0) && in_h;
    if (rd) begin
      void'(exp_q.pop_front());
      sent_px++;
      if (sent_px % 64 == 0) begin
        blocks_sent++;
        if (blocks_sent == IMG_BLOCKS) done = 1;
      end
    end
    if (wr) begin
      part_q.push_back(conv_model(in_v));
      if (part_q.size() == 64) begin
        foreach (part_q[k]) exp_q.push_back(part_q[k]);
        part_q.delete();
      end
    end
  endtask

  task automatic drive(input logic g, input logic [10:0] v, input logic h);
    @(negedge clk);
    in_g = g; in_v = v; in_h = h;
    bus.yaz_gecerli_i = g;
    bus.yaz_veri_i    = v;
    bus.idct_hazir_i  = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_edge();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    drive(1'b0, '0, 1'b0);
    compared++;
    if (obs_vec() !== 18'h20000) begin
      mismatched++;
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), 18'h20000);
    end
    tick();
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b0, '0, 1'b0);
    compared++;
    if (obs_vec() !== model_vec()) begin
      mismatched++;
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), model_vec());
    end
  endtask

  task automatic drain(input string name, input int unsigned max_cyc);
    int unsigned n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      drive(1'b0, '0, 1'b1);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL %s drain n=%0d got=%h exp=%h", name, n, obs_vec(), model_vec());
      end
      tick();
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s drain_timeout left=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 11'(i), 1'b1);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL basic_wr i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
      end
      tick();
    end
    drain("basic", 100);
  endtask

  task automatic test_stall();
    int unsigned n = 0;
    int          st = 0;
    bit          h;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 11'(i), 1'b0);
      tick();
    end
    while (exp_q.size() > 0 && n < 100) begin
      h = !((sent_px % 64 == 20) && st < 5);
      if (!h) st++;
      drive(1'b0, '0, h);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL stall n=%0d got=%h exp=%h", n, obs_vec(), model_vec());
      end
      tick();
      n++;
    end
    compared++;
    if (st != 5 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL stall_done st=%0d left=%0d exp=5/0", st, exp_q.size());
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 130; i++) begin
      drive(1'b1, 11'($urandom_range(0, 2047)), 1'b0);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL full_wr i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    compared++;
    if (bus.yaz_hazir_o !== 1'b0 || exp_q.size() != 128) begin
      mismatched++;
      $display("FAIL full_hazir got=%b exp=0 queued=%0d", bus.yaz_hazir_o, exp_q.size());
    end
    drain("full", 300);
  endtask

  task automatic test_sat();
    logic [10:0] v;
    for (int i = 0; i < 64; i++) begin
      case (i)
        0:       v = 11'h7FB;
        1:       v = 11'd300;
        2:       v = 11'd77;
        default: v = 11'($urandom_range(0, 2047));
      endcase
      drive(1'b1, v, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL sat i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
      end
      tick();
    end
    drain("sat", 100);
  endtask

  task automatic test_random_to_end();
    int unsigned n = 0;
    while (!done && n < 6000) begin
      drive(($urandom % 4) != 0, 11'($urandom_range(0, 2047)), ($urandom % 3) != 0);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL random n=%0d got=%h exp=%h", n, obs_vec(), model_vec());
      end
      tick();
      n++;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL random_timeout blocks=%0d exp=%0d", blocks_sent, IMG_BLOCKS);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 11'($urandom_range(0, 2047)), 1'b1);
      compared++;
      if (obs_vec() !== model_vec() || bus.gonder_bitti_o !== 1'b1 || bus.yaz_hazir_o !== 1'b0) begin
        mismatched++;
        $display("FAIL after_done i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 11'($urandom_range(0, 255)), 1'b0);
      tick();
    end
    while (sent_px < 30) begin
      drive(1'b0, '0, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    rstn = 1'b0;
    model_reset();
    #1;
    compared++;
    if (obs_vec() !== 18'h20000) begin
      mismatched++;
      $display("FAIL reset_mid got=%h exp=%h", obs_vec(), 18'h20000);
    end
    tick();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 11'($urandom_range(0, 2047)), 1'b1);
      compared++;
      if (obs_vec() !== model_vec()) begin
        mismatched++;
        $display("FAIL reset_mid_wr i=%0d got=%h exp=%h", i, obs_vec(), model_vec());
      end
      tick();
    end
    drain("reset_mid", 100);
  endtask

  initial begin
    bus.yaz_gecerli_i = 1'b0;
    bus.yaz_veri_i    = '0;
    bus.idct_hazir_i  = 1'b0;
    in_g = 1'b0; in_v = '0; in_h = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_sat();
    test_random_to_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout compared=%0d", compared);
    $fatal(1);
  end

endmodule
